// File: rtl/sopc_counter_pkg.sv
// Shared types and constants for the SOPC counter system's RAM block-copy engine.
package sopc_counter_pkg;

  localparam int         COPIER_ADDR_W = 13;
  localparam int         COPIER_LEN_W  = 13;
  localparam int         COPIER_DATA_W = 32;
  localparam logic [3:0] COPIER_BE_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_FINISH  = 3'd4
  } copier_state_t;

endpackage

// File: rtl/sopc_counter_ram_copier_if.sv
// Avalon-MM word bus between the copy engine (master) and the on-chip RAM (slave).
//
// Handshake: a transfer is requested while avm_read or avm_write is high. If
// avm_waitrequest is high in that cycle the slave stalls and the master holds
// strobe, address and write data unchanged. The first cycle with the strobe
// high and avm_waitrequest low completes the request. Read data is returned
// later, qualified by avm_readdatavalid for exactly one cycle.
interface sopc_counter_ram_copier_if #(
  parameter int ADDR_W = sopc_counter_pkg::COPIER_ADDR_W,
  parameter int DATA_W = sopc_counter_pkg::COPIER_DATA_W
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    output avm_readdata, avm_readdatavalid, avm_waitrequest
  );
endinterface

// File: rtl/sopc_counter_copier_ptr.sv
// Source/destination word pointers and remaining-word count for the copy engine.
// Pointers wrap modulo 2^ADDR_W; last_o flags the final word of the block.
module sopc_counter_copier_ptr #(
  parameter int ADDR_W = 13,
  parameter int LEN_W  = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] src_nxt_o,
  output logic [ADDR_W-1:0] dst_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    cnt_d = cnt_q;
    if (load_i) begin
      src_d = src_i;
      dst_d = dst_i;
      cnt_d = len_i;
    end else if (step_i) begin
      src_d = src_q + ADDR_W'(1);
      dst_d = dst_q + ADDR_W'(1);
      cnt_d = cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      cnt_q <= cnt_d;
    end
  end

  // The FSM drives the next read address on the same edge the pointer steps.
  assign src_nxt_o = src_q + ADDR_W'(1);
  assign dst_o     = dst_q;
  assign last_o    = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/sopc_counter_ram_copier.sv
// Non-pipelined Avalon-MM block copier: one read then one write per word.
// Define SOPC_COPIER_CHECKSUM_EN to add a running 32-bit sum of copied words.
module sopc_counter_ram_copier
  import sopc_counter_pkg::*;
#(
  parameter int ADDR_W = COPIER_ADDR_W,
  parameter int LEN_W  = COPIER_LEN_W,
  parameter int DATA_W = COPIER_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
`ifdef SOPC_COPIER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output copier_state_t     state_dbg,
  sopc_counter_ram_copier_if.master avm
);

  copier_state_t     state_q;
  logic              busy_q;
  logic              done_q;
  logic              read_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              load;
  logic              step;
  logic              capture;
  logic [ADDR_W-1:0] src_nxt;
  logic [ADDR_W-1:0] dst_ptr;
  logic              last_word;

  assign load    = (state_q == ST_IDLE) && start;
  assign step    = (state_q == ST_WR_REQ) && !avm.avm_waitrequest;
  assign capture = (state_q == ST_RD_WAIT) && avm.avm_readdatavalid;

  sopc_counter_copier_ptr #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_ptr (
    .clk       (clk),
    .rst_n     (reset_n),
    .load_i    (load),
    .step_i    (step),
    .src_i     (src_addr),
    .dst_i     (dst_addr),
    .len_i     (len),
    .src_nxt_o (src_nxt),
    .dst_o     (dst_ptr),
    .last_o    (last_word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (len != '0) begin
              state_q <= ST_RD_REQ;
              read_q  <= 1'b1;
              addr_q  <= src_addr;
            end else begin
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RD_REQ: begin
          if (!avm.avm_waitrequest) begin
            read_q  <= 1'b0;
            state_q <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (avm.avm_readdatavalid) begin
            wdata_q <= avm.avm_readdata;
            write_q <= 1'b1;
            addr_q  <= dst_ptr;
            state_q <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: begin
          if (!avm.avm_waitrequest) begin
            write_q <= 1'b0;
            if (last_word) begin
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RD_REQ;
              read_q  <= 1'b1;
              addr_q  <= src_nxt;
            end
          end
        end
        ST_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          read_q  <= 1'b0;
          write_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SOPC_COPIER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum_q <= '0;
    end else if (load) begin
      checksum_q <= '0;
    end else if (capture) begin
      checksum_q <= checksum_q + avm.avm_readdata;
    end
  end

  assign checksum = checksum_q;
`else
  logic capture_unused;
  assign capture_unused = capture;
`endif

  assign busy               = busy_q;
  assign done               = done_q;
  assign state_dbg          = state_q;
  assign avm.avm_address    = addr_q;
  assign avm.avm_read       = read_q;
  assign avm.avm_write      = write_q;
  assign avm.avm_writedata  = wdata_q;
  assign avm.avm_byteenable = COPIER_BE_ALL;

endmodule

// File: tb/tb_sopc_counter_ram_copier.sv
// Bench for sopc_counter_ram_copier: RAM slave with random stalls/latency and a
// word-level copy reference model. Define SOPC_COPIER_CHECKSUM_EN to check the checksum.
module tb_sopc_counter_ram_copier;
  import sopc_counter_pkg::*;

  localparam int AW    = 13;
  localparam int DEPTH = 8192;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [12:0]   len = '0;
  logic          busy;
  logic          done;
  copier_state_t state_dbg;
`ifdef SOPC_COPIER_CHECKSUM_EN
  logic [31:0]   checksum;
  logic [31:0]   done_sum;
`endif

  sopc_counter_ram_copier_if avm ();

  sopc_counter_ram_copier dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
`ifdef SOPC_COPIER_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .state_dbg (state_dbg),
    .avm       (avm.master)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM slave and bus monitor
  logic [31:0]   ram     [DEPTH];
  logic [31:0]   ref_mem [DEPTH];
  int            wait_pct = 0;
  int            lat_min = 1;
  int            lat_max = 1;
  int            pend_cnt = 0;
  logic [31:0]   pend_data = '0;
  int            rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int            busy_rise_cyc = 0, done_cyc = 0;
  logic          busy_prev = 1'b0;
  logic          stall_prev = 1'b0;
  logic [AW-1:0] addr_prev = '0;
  logic          rd_prev = 1'b0, wr_prev = 1'b0;
  logic [31:0]   wd_prev = '0;
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_log[$];

  always @(negedge clk) begin
    if (!reset_n) begin
      pend_cnt                  = 0;
      stall_prev                = 1'b0;
      busy_prev                 = 1'b0;
      avm.avm_readdatavalid     = 1'b0;
      avm.avm_waitrequest       = 1'b0;
      avm.avm_readdata          = '0;
    end else begin
      if (stall_prev) begin
        check("stall_read", avm.avm_read, rd_prev);
        check("stall_write", avm.avm_write, wr_prev);
        check("stall_addr", avm.avm_address, addr_prev);
        if (wr_prev) check("stall_wdata", avm.avm_writedata, wd_prev);
      end
      if (avm.avm_read || avm.avm_write)
        check("rd_wr_exclusive", avm.avm_read && avm.avm_write, 1'b0);
      avm.avm_waitrequest   = ($urandom_range(99) < wait_pct);
      avm.avm_readdatavalid = 1'b0;
      avm.avm_readdata      = $urandom;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          avm.avm_readdatavalid = 1'b1;
          avm.avm_readdata      = pend_data;
        end
      end
      if (avm.avm_read && !avm.avm_waitrequest) begin
        rd_log.push_back(avm.avm_address);
        rd_cnt++;
        pend_data = ram[avm.avm_address];
        pend_cnt  = $urandom_range(lat_max, lat_min);
      end
      if (avm.avm_write && !avm.avm_waitrequest) begin
        ram[avm.avm_address] = avm.avm_writedata;
        wr_log.push_back(avm.avm_address);
        wr_cnt++;
      end
      stall_prev = (avm.avm_read || avm.avm_write) && avm.avm_waitrequest;
      addr_prev  = avm.avm_address;
      rd_prev    = avm.avm_read;
      wr_prev    = avm.avm_write;
      wd_prev    = avm.avm_writedata;
      if (busy && !busy_prev) busy_rise_cyc = cyc;
      busy_prev = busy;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
`ifdef SOPC_COPIER_CHECKSUM_EN
        done_sum = checksum;
`endif
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic mem_check(input string tag);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic run_copy(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [12:0] n, input bit poke,
                          output int lat_busy, output int lat_start);
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_wr_q[$];
    logic [31:0]   exp_sum = '0;
    int            start_cyc;
    // scoreboard: ascending word-by-word copy on the reference memory
    for (int i = 0; i < int'(n); i++) begin
      int sa = (int'(s) + i) % DEPTH;
      int da = (int'(d) + i) % DEPTH;
      exp_q.push_back(AW'(sa));
      exp_wr_q.push_back(AW'(da));
      exp_sum += ref_mem[sa];
      ref_mem[da] = ref_mem[sa];
    end
    rd_log.delete();
    wr_log.delete();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    start = 1'b1; src_addr = s; dst_addr = d; len = n;
    start_cyc = cyc;
    tick();
    start = 1'b0; src_addr = AW'($urandom); dst_addr = AW'($urandom); len = 13'($urandom);
    for (int k = 0; k < 5000 && done_cnt == 0; k++) begin
      tick();
      if (poke && k == 3) begin
        start = 1'b1; src_addr = AW'($urandom); dst_addr = AW'($urandom); len = 13'd5;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, done_cnt != 0, 1'b1);
    lat_busy  = done_cyc - busy_rise_cyc;
    lat_start = done_cyc - start_cyc;
    repeat (6) tick();
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_busy_low"}, busy, 1'b0);
    check({tag, "_reads"}, rd_cnt, n);
    check({tag, "_writes"}, wr_cnt, n);
    check({tag, "_rd_log_len"}, rd_log.size(), exp_q.size());
    check({tag, "_wr_log_len"}, wr_log.size(), exp_wr_q.size());
    for (int i = 0; i < exp_q.size() && i < rd_log.size(); i++)
      check($sformatf("%s_rd_addr%0d", tag, i), rd_log[i], exp_q[i]);
    for (int i = 0; i < exp_wr_q.size() && i < wr_log.size(); i++)
      check($sformatf("%s_wr_addr%0d", tag, i), wr_log[i], exp_wr_q[i]);
    mem_check({tag, "_mem"});
`ifdef SOPC_COPIER_CHECKSUM_EN
    check({tag, "_sum_at_done"}, done_sum, exp_sum);
    check({tag, "_sum_held"}, checksum, exp_sum);
`else
    exp_sum = '0;
`endif
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int lb, ls;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_read", avm.avm_read, 1'b0);
    check("rst_write", avm.avm_write, 1'b0);
    check("rst_addr", avm.avm_address, '0);
    check("rst_wdata", avm.avm_writedata, '0);
    check("rst_be", avm.avm_byteenable, 4'hF);
`ifdef SOPC_COPIER_CHECKSUM_EN
    check("rst_checksum", checksum, '0);
`endif
    reset_n = 1'b1;
    repeat (2) tick();

    // directed block copy, zero-wait slave, latency 1
    ram[0] = 32'h11111111; ram[1] = 32'h22222222; ram[2] = 32'h33333333; ram[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) ref_mem[i] = ram[i];
    run_copy("basic", 13'd0, 13'd100, 13'd4, 1'b0, lb, ls);
    check("basic_done_latency", lb, 12);
    check("basic_word103", ram[103], 32'h44444444);

    run_copy("len0", 13'd7, 13'd9, 13'd0, 1'b0, lb, ls);
    check("len0_done_latency", ls, 1);

    run_copy("wrap", 13'd8190, 13'd10, 13'd3, 1'b0, lb, ls);

    // random stalls and read latency
    wait_pct = 50; lat_min = 1; lat_max = 4;
    run_copy("rand16", AW'($urandom_range(DEPTH - 1)), AW'($urandom_range(DEPTH - 1)),
             13'd16, 1'b0, lb, ls);
    run_copy("overlap", 13'd900, 13'd901, 13'd4, 1'b0, lb, ls);
    check("overlap_replicated", ram[904], ram[900]);
    wait_pct = 0; lat_min = 1; lat_max = 1;

    // reset aborts a copy after two words
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    start = 1'b1; src_addr = 13'd200; dst_addr = 13'd300; len = 13'd8;
    tick();
    start = 1'b0;
    for (int k = 0; k < 200 && wr_cnt < 2; k++) tick();
    check("abort_two_writes", wr_cnt, 2);
    tick();
    for (int i = 0; i < 2; i++) ref_mem[300 + i] = ref_mem[200 + i];
    #2 reset_n = 1'b0;
    #1;
    check("abort_read", avm.avm_read, 1'b0);
    check("abort_write", avm.avm_write, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check("abort_no_done", done_cnt, 0);
    mem_check("abort_mem");
    run_copy("after_abort", 13'd400, 13'd500, 13'd5, 1'b0, lb, ls);

    // checksum words and start while busy
    ram[600] = 32'h00000001; ram[601] = 32'h00000002; ram[602] = 32'hFFFFFFFF;
    for (int i = 600; i < 603; i++) ref_mem[i] = ram[i];
    run_copy("sum3", 13'd600, 13'd700, 13'd3, 1'b1, lb, ls);
`ifdef SOPC_COPIER_CHECKSUM_EN
    check("sum3_value", checksum, 32'h00000002);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sopc_counter_ram_copier.md
Name: sopc_counter_ram_copier

Overview:
- Avalon-MM master block-copy engine; the initiator side of the single-port 32-bit on-chip RAM slave in the SOPC counter system.
- Copies LEN 32-bit words from a source word address to a destination word address in the same RAM.
- Sequencing: one read, then one write per word; non-pipelined.
- Started by a one-cycle pulse from control logic; reports busy, done and an optional checksum.

Parameters:
- ADDR_W, 13, word-address width; matches the RAM's 13-bit address.
- LEN_W, 13, width of the word-count input.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- src_addr  input  ADDR_W  first source word address; latched on an accepted start.
- dst_addr  input  ADDR_W  first destination word address; latched on an accepted start.
- len  input  LEN_W  number of words; latched on an accepted start.
- busy  output  1  high from the cycle after an accepted start until DONE completes.
- done  output  1  one-cycle pulse when the copy finishes.
- avm_address  output  ADDR_W  word address.
- avm_read  output  1  read strobe.
- avm_write  output  1  write strobe.
- avm_byteenable  output  4  constant 4'hF.
- avm_writedata  output  DATA_W  write data.
- avm_readdata  input  DATA_W  read data.
- avm_readdatavalid  input  1  read data qualifier.
- avm_waitrequest  input  1  slave stall.

Behaviour:
- Reset values: busy=0, done=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0. Internal counters and pointers also reset to 0.
- Reset is asynchronous: assertion mid-transfer aborts immediately, drops strobes that same instant, and sends no done.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH.
- IDLE, start=1, len!=0: latch inputs, then go to RD_REQ.
- IDLE, start=1, len==0: go to FINISH. No bus traffic.
- start outside IDLE: ignored.
- RD_REQ: avm_read=1, avm_address=src pointer.
  - Address and strobe stay stable while avm_waitrequest=1.
  - When waitrequest=0, the read is accepted: go to RD_WAIT and deassert avm_read the next cycle.
- RD_WAIT: wait for avm_readdatavalid=1.
  - Capture avm_readdata into avm_writedata, then go to WR_REQ.
  - readdatavalid seen in any other state is ignored.
  - Readdatavalid in the same cycle as acceptance is not possible (slave latency ≥1); treat it as the RD_WAIT capture only if it occurs in RD_WAIT.
- WR_REQ: avm_write=1, avm_address=dst pointer.
  - Hold while waitrequest=1.
  - On acceptance: increment src and dst pointers modulo 2^ADDR_W (wrap 8191→0), and decrement the remaining count.
  - Then go to RD_REQ if remaining!=0, otherwise go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0 in the following cycle, then return to IDLE.
- avm_read and avm_write are never high together.
- Throughput with zero-wait slave and latency 1: 3 cycles per word (RD_REQ, RD_WAIT, WR_REQ).
- Overlapping regions: copy is strictly ascending. With dst>src and overlap, the result is a replicated pattern. This is documented behaviour, not an error.

Optional Feature:
- Macro: SOPC_COPIER_CHECKSUM_EN.
- Defined: adds output port checksum [DATA_W] (reset 0).
  - Cleared on an accepted start.
  - Adds each captured read word modulo 2^32.
  - Value is stable from the done pulse until the next accepted start.
- Undefined: no port and no adder logic.

Decomposition:
- Shared package sopc_counter_pkg:
  - state enum copier_state_t.
  - constants COPIER_ADDR_W=13, COPIER_DATA_W=32, COPIER_BE_ALL=4'hF.
- One natural sub-module: sopc_counter_copier_ptr, the address-pointer/count register pair with load, increment and wrap. Everything else stays in the top FSM.

Test Plan:
- Preload RAM[0..3]=32'h11111111,22222222,33333333,44444444; start src=0, dst=100, len=4, zero-wait slave, latency 1 → RAM[100..103] equals source; done pulses once at cycle 12 after the start cycle; 4 reads and 4 writes observed.
- len=0 start → done pulses 1 cycle later; avm_read and avm_write never asserted.
- src=8190, dst=10, len=3 → reads at 8190, 8191, 0; writes at 10, 11, 12.
- Random waitrequest (50%) and readdata latency 1–4 cycles, len=16 → address, writedata and strobes stable during every stall; data matches; exactly 16 writes.
- reset_n low mid-transfer (after 2 words of len=8) → strobes 0 immediately, no done; a new start after release copies correctly from fresh inputs.
- SOPC_COPIER_CHECKSUM_EN defined, words 1, 2, 32'hFFFFFFFF → checksum = 32'h00000002 at done. Start pulsed while busy → ignored, no second done.
